// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one memory-side request bus between the instruction L1 (rq0) and the
// data L1 (rq1). A registered grant selects which requester's fields are
// forwarded to memory. The owner sees the memory stall directly. The other
// port is held busy. Arbitration is round-robin. A requester can keep
// ownership across consecutive beats by holding i_rqN_lock.
//
// Ports
//   i_clock, i_reset          clock, synchronous active-high reset
//   i_rqN_addr/re/we/be/wdata requester N memory request fields
//   i_rqN_lock                keep ownership after the current beat
//   o_rqN_rdata               memory read data (broadcast)
//   o_rqN_busy                stall; low only in the owner's completion cycle
//   o_mem_addr/re/we/be/wdata forwarded request of the current owner
//   i_mem_rdata, i_mem_busy   memory response
//   o_owner                   00 none, 01 rq0, 10 rq1 (straight from state)
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int BE_W      = DATA_WIDTH / 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  // requester 0 (instruction cache)
  input  logic [ADDR_WIDTH-1:0] i_rq0_addr,
  input  logic                  i_rq0_re,
  input  logic                  i_rq0_we,
  input  logic [BE_W-1:0]       i_rq0_be,
  input  logic [DATA_WIDTH-1:0] i_rq0_wdata,
  input  logic                  i_rq0_lock,
  output logic [DATA_WIDTH-1:0] o_rq0_rdata,
  output logic                  o_rq0_busy,
  // requester 1 (data cache)
  input  logic [ADDR_WIDTH-1:0] i_rq1_addr,
  input  logic                  i_rq1_re,
  input  logic                  i_rq1_we,
  input  logic [BE_W-1:0]       i_rq1_be,
  input  logic [DATA_WIDTH-1:0] i_rq1_wdata,
  input  logic                  i_rq1_lock,
  output logic [DATA_WIDTH-1:0] o_rq1_rdata,
  output logic                  o_rq1_busy,
  // memory side
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_re,
  output logic                  o_mem_we,
  output logic [BE_W-1:0]       o_mem_be,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_mem_busy,
  // arbitration status
  output logic [1:0]            o_owner
);

  // State encoding doubles as the o_owner code, so o_owner is a pure register
  // output with no path from the requester inputs.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_t;

  state_t state_reg, state_next;
  logic   last_reg, last_next;   // last requester that completed a beat

  logic req0, req1;
  logic done0, done1;

  assign req0  = i_rq0_re | i_rq0_we;
  assign req1  = i_rq1_re | i_rq1_we;
  assign done0 = req0 & ~i_mem_busy;
  assign done1 = req1 & ~i_mem_busy;

  // Read data is common to both ports; only the owner's busy qualifies it.
  assign o_rq0_rdata = i_mem_rdata;
  assign o_rq1_rdata = i_mem_rdata;

  assign o_owner = state_reg;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;   // rq0 wins the first tie
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
    end
  end

  // Next-state logic. A release never returns to the same grant directly:
  // it goes to the other grant if that side is asking, otherwise to IDLE.
  // This is what makes a persistent requester yield to a waiting one.
  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    case (state_reg)
      IDLE: begin
        if (req0 && req1) begin
          state_next = last_reg ? GRANT0 : GRANT1;
        end else if (req0) begin
          state_next = GRANT0;
        end else if (req1) begin
          state_next = GRANT1;
        end
      end
      GRANT0: begin
        if (done0) begin
          last_next = 1'b0;
          if (!i_rq0_lock) begin
            state_next = req1 ? GRANT1 : IDLE;
          end
        end else if (!req0 && !i_rq0_lock) begin
          // request dropped without lock: abort and release
          state_next = req1 ? GRANT1 : IDLE;
        end
        // otherwise: stalled beat, or idle-but-locked hold
      end
      GRANT1: begin
        if (done1) begin
          last_next = 1'b1;
          if (!i_rq1_lock) begin
            state_next = req0 ? GRANT0 : IDLE;
          end
        end else if (!req1 && !i_rq1_lock) begin
          state_next = req0 ? GRANT0 : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output mux. The owner's fields pass straight through. A locked owner with
  // no request drives re = we = 0, so the bus sits idle without losing the grant.
  always_comb begin
    o_mem_addr  = '0;
    o_mem_re    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_be    = '0;
    o_mem_wdata = '0;
    o_rq0_busy  = 1'b1;
    o_rq1_busy  = 1'b1;
    case (state_reg)
      GRANT0: begin
        o_mem_addr  = i_rq0_addr;
        o_mem_re    = i_rq0_re;
        o_mem_we    = i_rq0_we;
        o_mem_be    = i_rq0_be;
        o_mem_wdata = i_rq0_wdata;
        o_rq0_busy  = i_mem_busy;
      end
      GRANT1: begin
        o_mem_addr  = i_rq1_addr;
        o_mem_re    = i_rq1_re;
        o_mem_we    = i_rq1_we;
        o_mem_be    = i_rq1_be;
        o_mem_wdata = i_rq1_wdata;
        o_rq1_busy  = i_mem_busy;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam logic [31:0] RD_XOR = 32'h5A5A_0000;

  logic        clk;
  logic        i_reset;
  logic [31:0] i_rq0_addr, i_rq1_addr;
  logic        i_rq0_re, i_rq0_we, i_rq1_re, i_rq1_we;
  logic [3:0]  i_rq0_be, i_rq1_be;
  logic [31:0] i_rq0_wdata, i_rq1_wdata;
  logic        i_rq0_lock, i_rq1_lock;
  logic [31:0] o_rq0_rdata, o_rq1_rdata;
  logic        o_rq0_busy, o_rq1_busy;
  logic [31:0] o_mem_addr;
  logic        o_mem_re, o_mem_we;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;
  logic        i_mem_busy;
  logic [1:0]  o_owner;

  mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .i_clock     (clk),
    .i_reset     (i_reset),
    .i_rq0_addr  (i_rq0_addr),
    .i_rq0_re    (i_rq0_re),
    .i_rq0_we    (i_rq0_we),
    .i_rq0_be    (i_rq0_be),
    .i_rq0_wdata (i_rq0_wdata),
    .i_rq0_lock  (i_rq0_lock),
    .o_rq0_rdata (o_rq0_rdata),
    .o_rq0_busy  (o_rq0_busy),
    .i_rq1_addr  (i_rq1_addr),
    .i_rq1_re    (i_rq1_re),
    .i_rq1_we    (i_rq1_we),
    .i_rq1_be    (i_rq1_be),
    .i_rq1_wdata (i_rq1_wdata),
    .i_rq1_lock  (i_rq1_lock),
    .o_rq1_rdata (o_rq1_rdata),
    .o_rq1_busy  (o_rq1_busy),
    .o_mem_addr  (o_mem_addr),
    .o_mem_re    (o_mem_re),
    .o_mem_we    (o_mem_we),
    .o_mem_be    (o_mem_be),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_rdata (i_mem_rdata),
    .i_mem_busy  (i_mem_busy),
    .o_owner     (o_owner)
  );

  // Memory model: read data is a fixed function of the presented address.
  assign i_mem_rdata = o_mem_addr ^ RD_XOR;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]  owner;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } beat_t;

  beat_t sb_q[$];
  beat_t exp_beat;
  int    n_compared   = 0;
  int    n_mismatched = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_beat(input logic [1:0] owner, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
    beat_t b;
    b.owner = owner;
    b.we    = we;
    b.addr  = addr;
    b.wdata = wdata;
    b.be    = be;
    sb_q.push_back(b);
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every completed memory beat pops one expectation.
  always @(negedge clk) begin
    if (!i_reset && (o_mem_re || o_mem_we) && !i_mem_busy) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_underflow", 64'(sb_q.size()), 64'd1);
      end else begin
        exp_beat = sb_q.pop_front();
        $display("beat owner=%b we=%b addr=%h wdata=%h be=%h", o_owner, o_mem_we,
                 o_mem_addr, o_mem_wdata, o_mem_be);
        check_eq("beat_owner", 64'(o_owner), 64'(exp_beat.owner));
        check_eq("beat_we", 64'(o_mem_we), 64'(exp_beat.we));
        check_eq("beat_addr", 64'(o_mem_addr), 64'(exp_beat.addr));
        check_eq("beat_be", 64'(o_mem_be), 64'(exp_beat.be));
        check_eq("beat_wdata", 64'(o_mem_wdata), 64'(exp_beat.wdata));
        if (exp_beat.owner == 2'b01) begin
          check_eq("beat_rq0_busy", 64'(o_rq0_busy), 64'd0);
          check_eq("beat_rq1_busy", 64'(o_rq1_busy), 64'd1);
          if (!exp_beat.we) check_eq("beat_rq0_rdata", 64'(o_rq0_rdata), 64'(exp_beat.addr ^ RD_XOR));
        end else begin
          check_eq("beat_rq1_busy", 64'(o_rq1_busy), 64'd0);
          check_eq("beat_rq0_busy", 64'(o_rq0_busy), 64'd1);
          if (!exp_beat.we) check_eq("beat_rq1_rdata", 64'(o_rq1_rdata), 64'(exp_beat.addr ^ RD_XOR));
        end
      end
    end
  end

  initial begin
    i_reset = 1'b1;
    i_rq0_addr = '0; i_rq0_re = 0; i_rq0_we = 0; i_rq0_be = '0; i_rq0_wdata = '0; i_rq0_lock = 0;
    i_rq1_addr = '0; i_rq1_re = 0; i_rq1_we = 0; i_rq1_be = '0; i_rq1_wdata = '0; i_rq1_lock = 0;
    i_mem_busy = 1'b0;

    // ---- reset values ----
    repeat (3) step();
    #1;
    check_eq("rst_owner", 64'(o_owner), 64'd0);
    check_eq("rst_mem_re", 64'(o_mem_re), 64'd0);
    check_eq("rst_mem_we", 64'(o_mem_we), 64'd0);
    check_eq("rst_mem_addr", 64'(o_mem_addr), 64'd0);
    check_eq("rst_mem_be", 64'(o_mem_be), 64'd0);
    check_eq("rst_mem_wdata", 64'(o_mem_wdata), 64'd0);
    check_eq("rst_rq0_busy", 64'(o_rq0_busy), 64'd1);
    check_eq("rst_rq1_busy", 64'(o_rq1_busy), 64'd1);
    check_eq("rst_rq0_rdata", 64'(o_rq0_rdata), 64'h5A5A_0000);

    // ---- reset mid-beat: rq1 granted with memory stalled ----
    i_reset = 1'b0;
    i_rq1_re = 1; i_rq1_addr = 32'h1F0; i_mem_busy = 1'b1;
    step(); #1;
    check_eq("midrst_owner_before", 64'(o_owner), 64'd2);
    check_eq("midrst_mem_re_before", 64'(o_mem_re), 64'd1);
    i_reset = 1'b1;
    step(); #1;
    check_eq("midrst_owner", 64'(o_owner), 64'd0);
    check_eq("midrst_mem_re", 64'(o_mem_re), 64'd0);
    check_eq("midrst_rq0_busy", 64'(o_rq0_busy), 64'd1);
    check_eq("midrst_rq1_busy", 64'(o_rq1_busy), 64'd1);
    i_reset = 1'b0; i_rq1_re = 0; i_mem_busy = 1'b0;

    // ---- tie and round-robin: first tie after reset goes to rq0 ----
    i_rq0_re = 1; i_rq0_addr = 32'h300;
    i_rq1_re = 1; i_rq1_addr = 32'h400;
    push_beat(2'b01, 0, 32'h300, 32'h0, 4'h0);
    push_beat(2'b10, 0, 32'h400, 32'h0, 4'h0);
    push_beat(2'b01, 0, 32'h300, 32'h0, 4'h0);
    push_beat(2'b10, 0, 32'h400, 32'h0, 4'h0);
    #1 check_eq("rr_idle", 64'(o_owner), 64'd0);
    step(); #1 check_eq("rr_own1", 64'(o_owner), 64'd1);
    step(); #1 check_eq("rr_own2", 64'(o_owner), 64'd2);
    step(); #1 check_eq("rr_own3", 64'(o_owner), 64'd1);
    step(); i_rq0_re = 0; #1 check_eq("rr_own4", 64'(o_owner), 64'd2);
    step(); i_rq1_re = 0; #1 check_eq("rr_end", 64'(o_owner), 64'd0);

    // ---- single read ----
    i_rq0_re = 1; i_rq0_addr = 32'h100;
    push_beat(2'b01, 0, 32'h100, 32'h0, 4'h0);
    #1 check_eq("rd_idle", 64'(o_owner), 64'd0);
    step(); #1;
    check_eq("rd_owner", 64'(o_owner), 64'd1);
    check_eq("rd_mem_re", 64'(o_mem_re), 64'd1);
    check_eq("rd_mem_addr", 64'(o_mem_addr), 64'h100);
    check_eq("rd_rq0_busy", 64'(o_rq0_busy), 64'd0);
    check_eq("rd_rq0_rdata", 64'(o_rq0_rdata), 64'(32'h100 ^ RD_XOR));
    step(); i_rq0_re = 0; #1 check_eq("rd_release", 64'(o_owner), 64'd0);

    // ---- locked burst by rq1 while rq0 waits (tie goes to rq1: rq0 served last) ----
    i_rq1_we = 1; i_rq1_be = 4'hF; i_rq1_addr = 32'h200; i_rq1_wdata = 32'hD000_0000; i_rq1_lock = 1;
    i_rq0_re = 1; i_rq0_addr = 32'h500;
    for (int i = 0; i < 4; i++) push_beat(2'b10, 1, 32'h200 + 32'(4 * i), 32'hD000_0000 + 32'(i), 4'hF);
    push_beat(2'b01, 0, 32'h500, 32'h0, 4'h0);
    #1 check_eq("burst_idle", 64'(o_owner), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      i_rq1_addr  = 32'h200 + 32'(4 * i);
      i_rq1_wdata = 32'hD000_0000 + 32'(i);
      i_rq1_lock  = (i < 3);
      #1;
      check_eq("burst_owner", 64'(o_owner), 64'd2);
      check_eq("burst_mem_we", 64'(o_mem_we), 64'd1);
      check_eq("burst_rq0_busy", 64'(o_rq0_busy), 64'd1);
    end
    step(); i_rq1_we = 0; i_rq1_lock = 0;
    #1 check_eq("burst_handover", 64'(o_owner), 64'd1);
    step(); i_rq0_re = 0; #1 check_eq("burst_end", 64'(o_owner), 64'd0);

    // ---- memory stall for 3 cycles ----
    i_rq0_re = 1; i_rq0_addr = 32'h600; i_mem_busy = 1'b1;
    push_beat(2'b01, 0, 32'h600, 32'h0, 4'h0);
    step();
    for (int j = 0; j < 3; j++) begin
      #1;
      check_eq("stall_owner", 64'(o_owner), 64'd1);
      check_eq("stall_rq0_busy", 64'(o_rq0_busy), 64'd1);
      check_eq("stall_rq1_busy", 64'(o_rq1_busy), 64'd1);
      check_eq("stall_mem_addr", 64'(o_mem_addr), 64'h600);
      check_eq("stall_mem_re", 64'(o_mem_re), 64'd1);
      step();
    end
    i_mem_busy = 1'b0;
    #1;
    check_eq("stall_done_rq0_busy", 64'(o_rq0_busy), 64'd0);
    check_eq("stall_done_rq1_busy", 64'(o_rq1_busy), 64'd1);
    step(); i_rq0_re = 0; #1 check_eq("stall_end", 64'(o_owner), 64'd0);

    // ---- abort: rq1 drops its request while memory is stalled, rq0 pending ----
    i_rq1_re = 1; i_rq1_addr = 32'h700; i_mem_busy = 1'b1;
    step(); #1 check_eq("abort_owner", 64'(o_owner), 64'd2);
    step();
    i_rq1_re = 0;
    i_rq0_re = 1; i_rq0_addr = 32'h800;
    push_beat(2'b01, 0, 32'h800, 32'h0, 4'h0);
    #1;
    check_eq("abort_no_re", 64'(o_mem_re), 64'd0);
    check_eq("abort_no_we", 64'(o_mem_we), 64'd0);
    step(); i_mem_busy = 1'b0;
    #1 check_eq("abort_next_owner", 64'(o_owner), 64'd1);
    step(); i_rq0_re = 0; #1 check_eq("abort_end", 64'(o_owner), 64'd0);

    step();
    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter that shares the single memory-side data bus (toward L2 or main memory) between the instruction L1 cache (requester 0) and the data L1 cache (requester 1). It registers a grant, forwards the owner's request fields to memory, returns the memory busy/rdata to the owner, and holds every other requester stalled. Arbitration is round-robin, with an optional lock so a cache line fill or writeback keeps ownership across consecutive beats.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width. Byte-enable width BE_W = DATA_WIDTH/8.

Ports:
- i_clock  in  1  clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_rqN_addr  in  ADDR_WIDTH  request address (N = 0, 1).
- i_rqN_re / i_rqN_we  in  1  read / write request; never both high.
- i_rqN_be  in  BE_W  byte enables for writes.
- i_rqN_wdata  in  DATA_WIDTH  write data.
- i_rqN_lock  in  1  keep ownership after the current beat completes.
- o_rqN_rdata  out  DATA_WIDTH  read data (i_mem_rdata broadcast to both ports).
- o_rqN_busy  out  1  stall; low only in the completion cycle of the owner.
- o_mem_addr / o_mem_re / o_mem_we / o_mem_be / o_mem_wdata  out  memory request, same widths as the requester fields.
- i_mem_rdata  in  DATA_WIDTH  memory read data, valid when i_mem_busy is low.
- i_mem_busy  in  1  memory stall.
- o_owner  out  2  current owner: 00 none, 01 rq0, 10 rq1.

## Operation
- reqN = i_rqN_re | i_rqN_we.
- FSM states: IDLE, GRANT0, GRANT1. Register `last`, holding the last requester served.
- IDLE:
  - Only req0 high -> GRANT0. Only req1 high -> GRANT1.
  - Both high -> grant the requester that is not `last`.
  - Neither high -> stay in IDLE.
- GRANTn:
  - Memory outputs = requester n fields, passed through combinationally.
  - o_rqn_busy = i_mem_busy. The other port's busy = 1.
  - Beat completes when reqn & ~i_mem_busy; `last` <= n on completion.
- Leaving GRANTn:
  - Beat completes with i_rqn_lock = 1 -> stay in GRANTn.
  - Beat completes with lock = 0, or reqn = 0 and lock = 0 (drop/abort) -> release.
  - Release goes to GRANT(other) if the other requester's req is high in that cycle, otherwise to IDLE.
  - A requester re-requesting right after an unlocked release always passes through IDLE or the other grant. This guarantees fairness.
- reqn = 0 with lock = 1 -> hold GRANTn with the bus idle (no memory strobe).
- IDLE or no owner: o_mem_re = o_mem_we = 0; o_mem_addr, o_mem_be and o_mem_wdata = 0; both busy = 1.
- o_owner decodes the state directly.
- Reset mid-transaction: state IDLE, any beat is abandoned, and strobes drop in the cycle after the reset edge. Requesters must reissue.

## Timing
- Reset values:
  - state IDLE, `last` = 1 (rq0 wins the first tie).
  - o_owner = 00; o_mem_re, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata = 0.
  - o_rq0_busy = o_rq1_busy = 1; o_rqN_rdata = i_mem_rdata.
- Arbitration latency: one cycle.
  - Request seen in IDLE at edge k -> owner from cycle k+1.
  - Memory strobe visible in cycle k+1; earliest completion in cycle k+1 if i_mem_busy = 0.
- Back-to-back:
  - Locked beats: one beat per cycle, no bubble.
  - Handover to a waiting requester: zero idle cycles.
  - Same requester re-acquiring after an unlocked release with no competitor: one IDLE bubble.
- Requesters hold addr, strobes and data stable while busy is high (same contract as the memory side).
- No combinational path from any i_rqN input to o_owner.

## Test plan
- Reset: assert i_reset with rq1 active mid-beat -> next cycle o_owner = 00, mem strobes 0, both busy 1. First tie after release resolves to rq0.
- Single read: rq0 re, addr 0x100, i_mem_busy = 0 -> cycle+1 o_mem_re = 1, o_mem_addr = 0x100; o_rq0_busy = 0 that cycle; o_rq0_rdata = i_mem_rdata; then IDLE.
- Tie and round-robin: rq0 and rq1 requesting continuously, one beat each, unlocked -> owner sequence 01, 10, 01, 10 with zero bubbles between grants.
- Locked burst: rq1 writes 4 beats at 0x200..0x20C with lock = 1 for the first 3; rq0 requesting throughout -> 4 consecutive mem writes (be = 0xF) with no interleaving, then rq0 granted the next cycle.
- Memory stall: rq0 granted, i_mem_busy high for 3 cycles -> o_rq0_busy high for 3 cycles, o_mem fields stable, completion in the 4th cycle, rq1 busy throughout.
- Abort: rq1 granted, drops re with lock = 0 while i_mem_busy = 1 -> next cycle owner 00 (or 01 if rq0 pending) and no memory strobe from rq1.
